mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and write-back by driving every mux select and write enable of the datapath from the opcode `Instruction[31:26]`. Adds a memory wait handshake (`mem_ready`), an illegal-opcode flag and a retired-instruction counter. Sits beside `ALUcontrol` in the processor top and drives the same control nets.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter.

Ports:
- `clk`  in  1  processor clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  `Instruction[31:26]` from the instruction register.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `PCWriteCond`  out  1  PC write if ALU Zero (beq).
- `PCWrite`  out  1  unconditional PC write.
- `IorD`  out  1  address select: 0=PC, 1=ALUOut.
- `MemRead`, `MemWrite`  out  1 each  memory strobes.
- `MemtoReg`  out  1  write-data select: 0=ALUOut, 1=MDR.
- `IRWrite`  out  1  instruction register load.
- `PCSource`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `ALUOp`  out  2  00=add, 01=sub, 10=funct field.
- `ALUSrcB`  out  2  00=B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `ALUSrcA`  out  1  0=PC, 1=A.
- `RegWrite`  out  1  register file write.
- `RegDst`  out  1  0=rt, 1=rd.
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode.
- `state_o`  out  4  current state encoding (debug).
- `retired`  out  CNT_W  instructions completed since reset.

## Operation
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000; all others illegal.
- States (4-bit encodings 0–11): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite assert only in the cycle `mem_ready`=1, and the FSM then moves to DECODE. Otherwise it holds FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state: lw/sw→MEM_ADDR, R→R_EXEC, addi→I_EXEC, beq→BRANCH, j→JUMP. Illegal opcode: `illegal_op`=1 and next state FETCH. PC already holds PC+4, so execution continues with the next instruction.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw→MEM_RD, sw→MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until `mem_ready`, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_WB.
- R_WB: RegWrite=1, MemtoReg=0, RegDst=1. Next state FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state I_WB.
- I_WB: RegWrite=1, MemtoReg=0, RegDst=0. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Any signal not listed for a state is 0.
- `retired` increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, I_WB, BRANCH or JUMP. Illegal opcodes do not count. The counter wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH and `retired`=0, both asynchronous. While `rst_n`=0, all write enables, strobes and `illegal_op` are forced to 0 and all selects read 0. After release, FETCH decoding applies from the same cycle.
- Outputs are combinational from the registered state. `mem_ready` gates IRWrite and PCWrite in FETCH, and the next-state choice in FETCH, MEM_RD and MEM_WR.
- Cycles per instruction with `mem_ready` held 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2. Each cycle `mem_ready`=0 in a memory state adds exactly one cycle.
- `mem_ready` is ignored in non-memory states.
- `opcode` is sampled in DECODE and MEM_ADDR only. The IR is stable there because IRWrite=0.
- Reset asserted mid-instruction: aborts immediately to FETCH. No partial write is issued after `rst_n` rises.

## Structure
- Package `mips_ctrl_pkg`: state enum (4-bit), opcode constants, and the ALUOp/ALUSrcB/PCSource encodings (also for `ALUcontrol` and the muxes).
- Sub-module `mips_ctrl_decode`: purely combinational state (plus `mem_ready`) → control-vector decoder. The top holds the state register, next-state logic and counter.

## Test plan
- Reset mid-MEM_WR (`rst_n` low, then high) → MemWrite=0 immediately, state_o=FETCH, retired=0.
- lw, `mem_ready`=1 → states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB over 5 cycles. RegWrite=1, MemtoReg=1 only in cycle 5. `retired` 0→1.
- sw with `mem_ready`=0 for 3 cycles in MEM_WR → MemWrite held 4 cycles, FETCH on cycle 8, single `retired` increment.
- FETCH with `mem_ready`=0 for 2 cycles → IRWrite/PCWrite low for 2 cycles, then both high for exactly one cycle.
- beq then j → BRANCH drives PCWriteCond=1, ALUOp=01, PCSource=01. JUMP drives PCWrite=1, PCSource=10. 3 cycles each, `retired`=2.
- opcode=111111 → `illegal_op` pulses 1 cycle in DECODE, next state FETCH, `retired` unchanged. Preload `retired`=0xFFFFFFFF via 2^32 instructions (or force) → next retire wraps to 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: state
// encodings, supported opcodes, datapath select encodings and the packed
// control vector that the decoder hands to the top level.
package mips_ctrl_pkg;

  // FSM states; the numeric values are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // Instruction[31:26] values understood by this controller.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp encodings, shared with ALUcontrol.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand mux selects.
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU A-operand mux selects.
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  // PC source mux selects.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every mux select and enable the FSM drives into the datapath.
  typedef struct packed {
    logic       pc_write_cond;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  // All enables off, all selects zero.
  localparam ctrl_t CTRL_IDLE = '{default: '0};

  // True for opcodes that have an execution path through the FSM.
  function automatic logic is_supported_op(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True for the final state of an instruction; leaving it for FETCH
  // means one instruction has retired.
  function automatic logic is_retire_state(input state_e st);
    logic r;
    case (st)
      S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control-vector decoder: turns the current FSM state (and
// mem_ready, which gates the instruction fetch strobes) into every mux
// select and write enable of the multicycle datapath.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state control vector; anything a state does not mention stays 0.
  always_comb begin
    ctrl_o = CTRL_IDLE;
    case (state_i)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed, together
        // with the IR load, in the cycle memory returns the instruction.
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_dst    = 1'b1;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = SRCA_A;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_I_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
        ctrl_o.reg_dst    = 1'b0;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = SRCA_A;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      default: begin
        ctrl_o = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Holds the state register,
// the opcode/mem_ready driven next-state logic and the retired-instruction
// counter; the control vector itself comes from mips_ctrl_decode. All
// enables are forced off while rst_n is low so nothing reaches the datapath
// during reset.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl_s;
  ctrl_t            ctrl_out_s;
  logic             illegal_s;
  logic             illegal_out_s;

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_s)
  );

  // Next state: opcode is only consulted in DECODE and MEM_ADDR (IR held),
  // mem_ready only in the memory states FETCH, MEM_RD and MEM_WR.
  always_comb begin
    state_d   = state_q;
    illegal_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_ADDI:      state_d = S_I_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            // PC already advanced in FETCH, so simply skip the instruction.
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        // Only lw/sw reach here; anything else falls back to FETCH.
        if (opcode == OP_SW)      state_d = S_MEM_WR;
        else if (opcode == OP_LW) state_d = S_MEM_RD;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD: begin
        if (mem_ready) state_d = S_MEM_WB;
        else           state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEM_WR;
      end
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retire count: one per completed instruction returning to FETCH.
  always_comb begin
    if (state_d == S_FETCH && is_retire_state(state_q)) begin
      retired_d = retired_q + CNT_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

  // State register and counter, both cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Force every enable and select to 0 while reset is held.
  always_comb begin
    if (!rst_n) begin
      ctrl_out_s    = CTRL_IDLE;
      illegal_out_s = 1'b0;
    end else begin
      ctrl_out_s    = ctrl_s;
      illegal_out_s = illegal_s;
    end
  end

  assign PCWriteCond = ctrl_out_s.pc_write_cond;
  assign PCWrite     = ctrl_out_s.pc_write;
  assign IorD        = ctrl_out_s.iord;
  assign MemRead     = ctrl_out_s.mem_read;
  assign MemWrite    = ctrl_out_s.mem_write;
  assign MemtoReg    = ctrl_out_s.mem_to_reg;
  assign IRWrite     = ctrl_out_s.ir_write;
  assign PCSource    = ctrl_out_s.pc_source;
  assign ALUOp       = ctrl_out_s.alu_op;
  assign ALUSrcB     = ctrl_out_s.alu_src_b;
  assign ALUSrcA     = ctrl_out_s.alu_src_a;
  assign RegWrite    = ctrl_out_s.reg_write;
  assign RegDst      = ctrl_out_s.reg_dst;
  assign illegal_op  = illegal_out_s;
  assign state_o     = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl. A second instance
// with a 3-bit counter shares all inputs so counter wrap is reachable in a
// few instructions. Inputs change just after the falling edge; outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  // Expected control vectors, bit order:
  // PCWriteCond PCWrite IorD MemRead MemWrite MemtoReg IRWrite
  // PCSource[1:0] ALUOp[1:0] ALUSrcB[1:0] ALUSrcA RegWrite RegDst
  localparam logic [15:0] E_ZERO     = 16'b0_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] E_FETCH_W  = 16'b0_0_0_1_0_0_0_00_00_01_0_0_0;
  localparam logic [15:0] E_FETCH_R  = 16'b0_1_0_1_0_0_1_00_00_01_0_0_0;
  localparam logic [15:0] E_DECODE   = 16'b0_0_0_0_0_0_0_00_00_11_0_0_0;
  localparam logic [15:0] E_MEM_ADDR = 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;
  localparam logic [15:0] E_MEM_RD   = 16'b0_0_1_1_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] E_MEM_WB   = 16'b0_0_0_0_0_1_0_00_00_00_0_1_0;
  localparam logic [15:0] E_MEM_WR   = 16'b0_0_1_0_1_0_0_00_00_00_0_0_0;
  localparam logic [15:0] E_R_EXEC   = 16'b0_0_0_0_0_0_0_00_10_00_1_0_0;
  localparam logic [15:0] E_R_WB     = 16'b0_0_0_0_0_0_0_00_00_00_0_1_1;
  localparam logic [15:0] E_I_EXEC   = 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;
  localparam logic [15:0] E_I_WB     = 16'b0_0_0_0_0_0_0_00_00_00_0_1_0;
  localparam logic [15:0] E_BRANCH   = 16'b1_0_0_0_0_0_0_01_01_00_1_0_0;
  localparam logic [15:0] E_JUMP     = 16'b0_1_0_0_0_0_0_10_00_00_0_0_0;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;

  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic        ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [3:0]  state_o;
  logic [31:0] retired;

  logic        w_pcwc, w_pcw, w_iord, w_mr, w_mw, w_m2r, w_irw;
  logic [1:0]  w_pcs, w_aluop, w_srcb;
  logic        w_srca, w_rw, w_rd, w_ill;
  logic [3:0]  w_state;
  logic [2:0]  w_retired;

  logic [15:0] obs_ctrl;
  logic [15:0] w_ctrl;

  int          checks;
  int          errors;
  int unsigned exp_ret;

  assign obs_ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};
  assign w_ctrl   = {w_pcwc, w_pcw, w_iord, w_mr, w_mw, w_m2r, w_irw,
                     w_pcs, w_aluop, w_srcb, w_srca, w_rw, w_rd};

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal_op(illegal_op), .state_o(state_o),
    .retired(retired)
  );

  mips_multicycle_ctrl #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(w_pcwc), .PCWrite(w_pcw), .IorD(w_iord),
    .MemRead(w_mr), .MemWrite(w_mw), .MemtoReg(w_m2r),
    .IRWrite(w_irw), .PCSource(w_pcs), .ALUOp(w_aluop),
    .ALUSrcB(w_srcb), .ALUSrcA(w_srca), .RegWrite(w_rw),
    .RegDst(w_rd), .illegal_op(w_ill), .state_o(w_state),
    .retired(w_retired)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OPC_LW;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_ctrl !== E_ZERO || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ctrl=%h illegal=%b, expected ctrl=%h illegal=0", obs_ctrl, illegal_op, E_ZERO);
    end
    checks++;
    if (state_o !== 4'd0 || retired !== 32'd0 || w_retired !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d retired=%0d w_retired=%0d, expected 0 0 0", state_o, retired, w_retired);
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || obs_ctrl !== E_FETCH_W) begin
      errors++;
      $display("FAIL reset_release: state=%0d ctrl=%h, expected 0 %h", state_o, obs_ctrl, E_FETCH_W);
    end
    exp_ret = 0;
  endtask

  // R-type preceded by two FETCH wait cycles.
  task automatic test_fetch_wait();
    logic        mr [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  st [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd6, 4'd7};
    logic [15:0] ex [6] = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_R_EXEC, E_R_WB};
    opcode = OPC_R;
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state_o !== st[i] || obs_ctrl !== ex[i] || illegal_op !== 1'b0 || retired !== exp_ret) begin
        errors++;
        $display("FAIL fetch_wait_c%0d: state=%0d ctrl=%h ill=%b ret=%0d, expected %0d %h 0 %0d",
                 i, state_o, obs_ctrl, illegal_op, retired, st[i], ex[i], exp_ret);
      end
      @(negedge clk);
    end
    exp_ret++;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || obs_ctrl !== E_FETCH_W || retired !== exp_ret ||
        w_retired !== exp_ret[2:0] || w_ctrl !== E_FETCH_W || w_state !== 4'd0 || w_ill !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait_done: state=%0d ctrl=%h ret=%0d w_ret=%0d w_ctrl=%h, expected 0 %h %0d %0d %h",
               state_o, obs_ctrl, retired, w_retired, w_ctrl, E_FETCH_W, exp_ret, exp_ret[2:0], E_FETCH_W);
    end
  endtask

  // lw; mem_ready dropped in non-memory states to show it is ignored there.
  task automatic test_lw();
    logic        mr [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [15:0] ex [5] = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_RD, E_MEM_WB};
    opcode = OPC_LW;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state_o !== st[i] || obs_ctrl !== ex[i] || illegal_op !== 1'b0 || retired !== exp_ret) begin
        errors++;
        $display("FAIL lw_c%0d: state=%0d ctrl=%h ill=%b ret=%0d, expected %0d %h 0 %0d",
                 i, state_o, obs_ctrl, illegal_op, retired, st[i], ex[i], exp_ret);
      end
      @(negedge clk);
    end
    exp_ret++;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || obs_ctrl !== E_FETCH_W || retired !== exp_ret || w_retired !== exp_ret[2:0]) begin
      errors++;
      $display("FAIL lw_done: state=%0d ctrl=%h ret=%0d w_ret=%0d, expected 0 %h %0d %0d",
               state_o, obs_ctrl, retired, w_retired, E_FETCH_W, exp_ret, exp_ret[2:0]);
    end
  endtask

  // sw with three wait cycles in MEM_WR: MemWrite held four cycles.
  task automatic test_sw_wait();
    logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0]  st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    logic [15:0] ex [7] = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_WR, E_MEM_WR, E_MEM_WR, E_MEM_WR};
    opcode = OPC_SW;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state_o !== st[i] || obs_ctrl !== ex[i] || illegal_op !== 1'b0 || retired !== exp_ret) begin
        errors++;
        $display("FAIL sw_wait_c%0d: state=%0d ctrl=%h ill=%b ret=%0d, expected %0d %h 0 %0d",
                 i, state_o, obs_ctrl, illegal_op, retired, st[i], ex[i], exp_ret);
      end
      @(negedge clk);
    end
    exp_ret++;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || obs_ctrl !== E_FETCH_W || retired !== exp_ret || w_retired !== exp_ret[2:0]) begin
      errors++;
      $display("FAIL sw_wait_done: state=%0d ctrl=%h ret=%0d w_ret=%0d, expected 0 %h %0d %0d",
               state_o, obs_ctrl, retired, w_retired, E_FETCH_W, exp_ret, exp_ret[2:0]);
    end
  endtask

  task automatic test_addi();
    logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd8, 4'd9};
    logic [15:0] ex [4] = '{E_FETCH_R, E_DECODE, E_I_EXEC, E_I_WB};
    opcode = OPC_ADDI;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state_o !== st[i] || obs_ctrl !== ex[i] || illegal_op !== 1'b0 || retired !== exp_ret) begin
        errors++;
        $display("FAIL addi_c%0d: state=%0d ctrl=%h ill=%b ret=%0d, expected %0d %h 0 %0d",
                 i, state_o, obs_ctrl, illegal_op, retired, st[i], ex[i], exp_ret);
      end
      @(negedge clk);
    end
    exp_ret++;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || retired !== exp_ret || w_retired !== exp_ret[2:0]) begin
      errors++;
      $display("FAIL addi_done: state=%0d ret=%0d w_ret=%0d, expected 0 %0d %0d",
               state_o, retired, w_retired, exp_ret, exp_ret[2:0]);
    end
  endtask

  // beq immediately followed by j, 3 cycles each; task name kept per scenario.
  task automatic test_back_to_back();
    logic [5:0]  op [6] = '{OPC_BEQ, OPC_BEQ, OPC_BEQ, OPC_J, OPC_J, OPC_J};
    logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd10, 4'd0, 4'd1, 4'd11};
    logic [15:0] ex [6] = '{E_FETCH_R, E_DECODE, E_BRANCH, E_FETCH_R, E_DECODE, E_JUMP};
    int unsigned ro [6] = '{0, 0, 0, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      opcode = op[i]; mem_ready = 1'b1;
      #1;
      checks++;
      if (state_o !== st[i] || obs_ctrl !== ex[i] || illegal_op !== 1'b0 || retired !== exp_ret + ro[i]) begin
        errors++;
        $display("FAIL beq_j_c%0d: state=%0d ctrl=%h ill=%b ret=%0d, expected %0d %h 0 %0d",
                 i, state_o, obs_ctrl, illegal_op, retired, st[i], ex[i], exp_ret + ro[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 2;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || retired !== exp_ret || w_retired !== exp_ret[2:0]) begin
      errors++;
      $display("FAIL beq_j_done: state=%0d ret=%0d w_ret=%0d, expected 0 %0d %0d",
               state_o, retired, w_retired, exp_ret, exp_ret[2:0]);
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [2] = '{4'd0, 4'd1};
    logic [15:0] ex [2] = '{E_FETCH_R, E_DECODE};
    logic        il [2] = '{1'b0, 1'b1};
    opcode = OPC_BAD;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state_o !== st[i] || obs_ctrl !== ex[i] || illegal_op !== il[i] || retired !== exp_ret) begin
        errors++;
        $display("FAIL illegal_c%0d: state=%0d ctrl=%h ill=%b ret=%0d, expected %0d %h %b %0d",
                 i, state_o, obs_ctrl, illegal_op, retired, st[i], ex[i], il[i], exp_ret);
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0 || illegal_op !== 1'b0 || retired !== exp_ret || w_ill !== 1'b0) begin
      errors++;
      $display("FAIL illegal_done: state=%0d ill=%b ret=%0d, expected 0 0 %0d",
               state_o, illegal_op, retired, exp_ret);
    end
  endtask

  // Two jumps take retired from 6 to 8; the 3-bit copy goes 6 -> 7 -> 0.
  task automatic test_wrap();
    logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd1, 4'd11};
    int unsigned ro [6] = '{0, 0, 0, 1, 1, 1};
    int unsigned e;
    opcode = OPC_J;
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      #1;
      e = exp_ret + ro[i];
      checks++;
      if (state_o !== st[i] || retired !== e || w_retired !== e[2:0] || w_state !== st[i]) begin
        errors++;
        $display("FAIL wrap_c%0d: state=%0d ret=%0d w_ret=%0d w_state=%0d, expected %0d %0d %0d %0d",
                 i, state_o, retired, w_retired, w_state, st[i], e, e[2:0], st[i]);
      end
      @(negedge clk);
    end
    exp_ret = exp_ret + 2;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (retired !== exp_ret || w_retired !== exp_ret[2:0]) begin
      errors++;
      $display("FAIL wrap_done: ret=%0d w_ret=%0d, expected %0d %0d", retired, w_retired, exp_ret, exp_ret[2:0]);
    end
  endtask

  task automatic test_reset_mid_write();
    opcode = OPC_SW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd5 || obs_ctrl !== E_MEM_WR) begin
      errors++;
      $display("FAIL rst_mid_pre: state=%0d ctrl=%h, expected 5 %h", state_o, obs_ctrl, E_MEM_WR);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || obs_ctrl !== E_ZERO || state_o !== 4'd0 || retired !== 32'd0 || w_retired !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_abort: MemWrite=%b ctrl=%h state=%0d ret=%0d w_ret=%0d, expected 0 %h 0 0 0",
               MemWrite, obs_ctrl, state_o, retired, w_retired, E_ZERO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd0 || obs_ctrl !== E_FETCH_W) begin
      errors++;
      $display("FAIL rst_mid_release: state=%0d ctrl=%h, expected 0 %h", state_o, obs_ctrl, E_FETCH_W);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state_o !== 4'd0 || MemWrite !== 1'b0 || retired !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_after: state=%0d MemWrite=%b ret=%0d, expected 0 0 0", state_o, MemWrite, retired);
    end
  endtask

  // Run all scenarios in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    exp_ret = 0;
    test_reset();
    test_fetch_wait();
    test_lw();
    test_sw_wait();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
